// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder: default operand width,
// feeder FSM state encoding and the signed operand pair payload.
package mac_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } feeder_state_t;

    typedef struct packed {
        logic signed [DEFAULT_DATA_W-1:0] a;
        logic signed [DEFAULT_DATA_W-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/operand_buffer.sv
// Operand-pair storage: DEPTH entries of WIDTH bits, synchronous write,
// combinational read. Contents are deliberately not reset.
// Ports: clk; wr_en/wr_addr/wr_data write port (out-of-range index dropped);
//        rd_addr/rd_data asynchronous read port.
module operand_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; indices past the last entry are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_operand_feeder.sv
// Stream source for the signed MAC: issues buffered operand pairs one per
// cycle (pause-aware), counts MAC result strobes, then signals completion
// or a drain timeout.
// Ports: clk, reset (sync, active-high); wr_en/wr_addr/wr_a/wr_b buffer load
//        (ignored while busy); len/start run control; pause issue hold;
//        mac_valid result strobe from the MAC; a/b/valid_out operand stream;
//        busy run status; done one-cycle completion; error sticky timeout.
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DRAIN_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic signed [DATA_W-1:0] wr_a,
    input  logic signed [DATA_W-1:0] wr_b,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     mac_valid,
    output logic signed [DATA_W-1:0] a,
    output logic signed [DATA_W-1:0] b,
    output logic                     valid_out,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(DRAIN_MAX + 1);
    localparam int unsigned PW = 2 * DATA_W;

    feeder_state_t            state, state_d;
    logic [LW-1:0]            len_q, len_d, len_clamped;
    logic [LW-1:0]            result_cnt, result_d;
    logic [AW-1:0]            issue_idx, issue_d;
    logic [CW-1:0]            drain_cnt, drain_d;
    logic signed [DATA_W-1:0] a_d, b_d;
    logic                     valid_d, busy_d, done_d, error_d;
    logic [PW-1:0]            rd_data;

    operand_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_data ({wr_a, wr_b}),
        .rd_addr (issue_idx),
        .rd_data (rd_data)
    );

    assign len_clamped = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        len_d    = len_q;
        issue_d  = issue_idx;
        result_d = result_cnt;
        drain_d  = drain_cnt;
        a_d      = a;
        b_d      = b;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        error_d  = error;

        // Result strobes count in any busy state, saturating at the run length.
        if ((state != IDLE) && mac_valid && (result_cnt < len_q)) begin
            result_d = result_cnt + LW'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    len_d    = len_clamped;
                    error_d  = 1'b0;
                    issue_d  = '0;
                    result_d = '0;
                    drain_d  = '0;
                    state_d  = (len_clamped != '0) ? ISSUE : FIN;
                end
            end
            ISSUE: begin
                if (!pause) begin
                    a_d     = rd_data[PW-1:DATA_W];
                    b_d     = rd_data[DATA_W-1:0];
                    valid_d = 1'b1;
                    issue_d = issue_idx + AW'(1);
                    if (LW'(issue_idx) == (len_q - LW'(1))) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (result_cnt == len_q) begin
                    state_d = FIN;
                end else if (drain_cnt == CW'(DRAIN_MAX - 1)) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end else begin
                    drain_d = drain_cnt + CW'(1);
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            issue_idx  <= '0;
            result_cnt <= '0;
            drain_cnt  <= '0;
            a          <= '0;
            b          <= '0;
            valid_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_d;
            len_q      <= len_d;
            issue_idx  <= issue_d;
            result_cnt <= result_d;
            drain_cnt  <= drain_d;
            a          <= a_d;
            b          <= b_d;
            valid_out  <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder: reference buffer plus expected
// pair queue, negedge monitor for the operand stream, and a simple MAC model
// that returns one result strobe per issued pair after a fixed latency.
module tb_mac_operand_feeder;
    import mac_pkg::*;

    localparam int DEPTH     = 16;
    localparam int DRAIN_MAX = 8;
    localparam int MAC_LAT   = 2;

    logic              clk = 1'b0;
    logic              reset, wr_en, start, pause, mac_valid;
    logic [3:0]        wr_addr;
    logic signed [7:0] wr_a, wr_b;
    logic [4:0]        len;
    logic signed [7:0] a, b;
    logic              valid_out, busy, done, error;

    always #5 clk = ~clk;

    mac_operand_feeder #(
        .DATA_W    (8),
        .DEPTH     (DEPTH),
        .DRAIN_MAX (DRAIN_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .len       (len),
        .start     (start),
        .pause     (pause),
        .mac_valid (mac_valid),
        .a         (a),
        .b         (b),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // MAC model: strobe MAC_LAT cycles after each issue, capped at mac_limit per run.
    logic d1 = 1'b0, d2 = 1'b0;
    int   mac_seen = 0;
    int   mac_limit = 0;
    always @(posedge clk) begin
        d1 <= valid_out;
        d2 <= d1;
        if (start && !busy) mac_seen <= 0;
        else if (mac_valid) mac_seen <= mac_seen + 1;
    end
    assign mac_valid = d2 && (mac_seen < mac_limit);

    operand_pair_t ref_buf [DEPTH];
    operand_pair_t exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Scoreboard monitor: every valid cycle must match the next expected pair.
    always @(negedge clk) begin
        if (!reset && valid_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: got a=%0d b=%0d expected no issue", a, b);
            end else begin
                operand_pair_t p;
                p = exp_q.pop_front();
                check("issue_a", a, p.a);
                check("issue_b", b, p.b);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int va, input int vb);
        wr_en   = 1'b1;
        wr_addr = 4'(idx);
        wr_a    = 8'(va);
        wr_b    = 8'(vb);
        tick();
        wr_en = 1'b0;
        ref_buf[idx].a = 8'(va);
        ref_buf[idx].b = 8'(vb);
    endtask

    // One run: expected pairs come from the reference buffer; latency, span,
    // busy length and error outcome follow from the run parameters.
    task automatic run(input int n, input int limit, input int pause_at, input int pause_len,
                       input bit disturb, input int reset_at, input string tag);
        int  neff, exp_err, cyc, vcnt, first, last, done_cyc, busy_cyc, pause_rem;
        bit  got_done;
        neff = (n > DEPTH) ? DEPTH : n;
        exp_err = (limit < neff) ? 1 : 0;
        for (int i = 0; i < neff; i++) exp_q.push_back(ref_buf[i]);
        mac_limit = limit;
        len   = 5'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; vcnt = 0; first = -1; last = -1; done_cyc = -1; pause_rem = 0;
        got_done = 1'b0;
        check({tag, "_busy_at_start"}, busy, 1);
        check({tag, "_error_cleared"}, error, 0);
        check({tag, "_no_issue_at_start"}, valid_out, 0);
        busy_cyc = busy ? 1 : 0;
        while (!got_done && cyc < 200) begin
            if (disturb && cyc == 1) begin
                start = 1'b1; len = 5'd1;
                wr_en = 1'b1; wr_addr = 4'd0; wr_a = 8'sh5a; wr_b = 8'sh5a;
            end else if (disturb && cyc == 2) begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (reset_at > 0 && cyc == reset_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check({tag, "_rst_a"}, a, 0);
                check({tag, "_rst_b"}, b, 0);
                check({tag, "_rst_valid"}, valid_out, 0);
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_done"}, done, 0);
                exp_q.delete();
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check({tag, "_rst_no_done"}, done, 0);
                end
                return;
            end
            tick();
            cyc++;
            if (busy) busy_cyc++;
            if (pause_rem > 0) begin
                check({tag, "_pause_valid"}, valid_out, 0);
                check({tag, "_pause_hold_a"}, a, ref_buf[pause_at-1].a);
                check({tag, "_pause_hold_b"}, b, ref_buf[pause_at-1].b);
                pause_rem--;
                if (pause_rem == 0) pause = 1'b0;
            end
            if (valid_out) begin
                vcnt++;
                if (first < 0) first = cyc;
                last = cyc;
                if (vcnt == pause_at && pause_len > 0) begin
                    pause = 1'b1;
                    pause_rem = pause_len;
                end
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
        end
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_valid_count"}, vcnt, neff);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_busy_cycles"}, busy_cyc, done_cyc);
        if (neff == 0) begin
            check({tag, "_done_latency"}, done_cyc, 1);
        end else begin
            check({tag, "_first_issue"}, first, 1);
            check({tag, "_issue_span"}, last - first + 1, neff + pause_len);
            check({tag, "_done_after_last"}, done_cyc - last,
                  exp_err ? DRAIN_MAX + 1 : MAC_LAT + 3);
        end
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_all_pairs_seen"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, pa, pl;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
        len = '0; start = 1'b0; pause = 1'b0;
        tick();
        tick();
        check("reset_a", a, 0);
        check("reset_b", b, 0);
        check("reset_valid", valid_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) load(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        load(0, -4, -2);
        load(1, -4, -1);
        load(2, -4, 0);
        load(3, -4, 1);

        run(4, 4, 0, 0, 1'b0, 0, "basic");
        run(4, 4, 2, 2, 1'b0, 0, "pause");
        run(0, 0, 0, 0, 1'b0, 0, "len0");
        run(3, 2, 0, 0, 1'b0, 0, "drain_to");
        run(4, 4, 0, 0, 1'b1, 0, "disturb");
        run(4, 4, 0, 0, 1'b0, 0, "reissue");
        run(8, 8, 0, 0, 1'b0, 3, "midreset");
        run(4, 4, 0, 0, 1'b0, 0, "after_reset");
        run(20, 20, 0, 0, 1'b0, 0, "clamp");

        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 3; j++)
                load(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)));
            n = int'($urandom_range(1, DEPTH));
            if (n > 1) begin
                pa = int'($urandom_range(1, n - 1));
                pl = int'($urandom_range(0, 3));
            end else begin
                pa = 0;
                pl = 0;
            end
            run(n, n, pa, pl, 1'b0, 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
